// File: rtl/neuron_alu_sequencer.sv
// Initiator-side sequencer that drives a shared combinational ALU to build a
// neuron dot product (MUL then ADD per pair) and a threshold compare (SLT).
// Every output is a flop loaded from the next-state decode, so the ALU sees
// operands that depend only on the current state, never on in_* or out_ready.
module neuron_alu_sequencer #(
   parameter int unsigned nBits   = 32,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned CW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [nBits-1:0] in_x,
   input  logic [nBits-1:0] in_w,
   input  logic             in_last,
   input  logic [nBits-1:0] threshold,
   output logic [2:0]       alu_ctrl,
   output logic [nBits-1:0] alu_src_a,
   output logic [nBits-1:0] alu_src_b,
   input  logic [nBits-1:0] alu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [nBits-1:0] out_sum,
   output logic             out_fire,
   output logic [CW-1:0]    out_count
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_SLT = 3'b010;

   typedef enum logic [2:0] {
      S_ACCEPT = 3'd0,
      S_MUL    = 3'd1,
      S_ADD    = 3'd2,
      S_CMP    = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [nBits-1:0] acc, acc_n;
   logic [nBits-1:0] prod, prod_n;
   logic [nBits-1:0] x_reg, x_reg_n;
   logic [nBits-1:0] w_reg, w_reg_n;
   logic [nBits-1:0] thr_reg, thr_reg_n;
   logic [CW-1:0]    count, count_n;
   logic             fire, fire_n;
   logic             last_eff, last_eff_n;

   logic             in_ready_n;
   logic             out_valid_n;
   logic [2:0]       alu_ctrl_n;
   logic [nBits-1:0] alu_src_a_n;
   logic [nBits-1:0] alu_src_b_n;
   logic [nBits-1:0] out_sum_n;
   logic             out_fire_n;
   logic [CW-1:0]    out_count_n;

   // Next-state, datapath update and next-output decode
   always_comb begin
      state_n    = state;
      acc_n      = acc;
      prod_n     = prod;
      x_reg_n    = x_reg;
      w_reg_n    = w_reg;
      thr_reg_n  = thr_reg;
      count_n    = count;
      fire_n     = fire;
      last_eff_n = last_eff;

      in_ready_n  = 1'b0;
      out_valid_n = 1'b0;
      alu_ctrl_n  = OP_ADD;
      alu_src_a_n = '0;
      alu_src_b_n = '0;
      out_sum_n   = '0;
      out_fire_n  = 1'b0;
      out_count_n = '0;

      case (state)
         S_ACCEPT: begin
            if (in_valid && in_ready) begin
               x_reg_n    = in_x;
               w_reg_n    = in_w;
               // The MAX_LEN-th pair closes the vector even without in_last
               last_eff_n = in_last | (count == CW'(MAX_LEN - 1));
               if (count == '0) begin
                  thr_reg_n = threshold;
               end
               count_n = count + CW'(1);
               state_n = S_MUL;
            end
         end
         S_MUL: begin
            prod_n  = alu_result;
            state_n = S_ADD;
         end
         S_ADD: begin
            acc_n   = alu_result;
            state_n = last_eff ? S_CMP : S_ACCEPT;
         end
         S_CMP: begin
            fire_n  = alu_result[0];
            state_n = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               acc_n   = '0;
               count_n = '0;
               state_n = S_ACCEPT;
            end
         end
         default: begin
            state_n = S_ACCEPT;
         end
      endcase

      // Outputs for the coming cycle are a pure function of the next state
      case (state_n)
         S_ACCEPT: begin
            in_ready_n = 1'b1;
         end
         S_MUL: begin
            alu_ctrl_n  = OP_MUL;
            alu_src_a_n = x_reg_n;
            alu_src_b_n = w_reg_n;
         end
         S_ADD: begin
            alu_ctrl_n  = OP_ADD;
            alu_src_a_n = acc_n;
            alu_src_b_n = prod_n;
         end
         S_CMP: begin
            alu_ctrl_n  = OP_SLT;
            alu_src_a_n = thr_reg_n;
            alu_src_b_n = acc_n;
         end
         S_OUT: begin
            out_valid_n = 1'b1;
            out_sum_n   = acc_n;
            out_fire_n  = fire_n;
            out_count_n = count_n;
         end
         default: begin
            in_ready_n = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_ACCEPT;
         acc       <= '0;
         prod      <= '0;
         x_reg     <= '0;
         w_reg     <= '0;
         thr_reg   <= '0;
         count     <= '0;
         fire      <= 1'b0;
         last_eff  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         alu_ctrl  <= OP_ADD;
         alu_src_a <= '0;
         alu_src_b <= '0;
         out_sum   <= '0;
         out_fire  <= 1'b0;
         out_count <= '0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         prod      <= prod_n;
         x_reg     <= x_reg_n;
         w_reg     <= w_reg_n;
         thr_reg   <= thr_reg_n;
         count     <= count_n;
         fire      <= fire_n;
         last_eff  <= last_eff_n;
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
         alu_ctrl  <= alu_ctrl_n;
         alu_src_a <= alu_src_a_n;
         alu_src_b <= alu_src_b_n;
         out_sum   <= out_sum_n;
         out_fire  <= out_fire_n;
         out_count <= out_count_n;
      end
   end

endmodule

// File: tb/tb_neuron_alu_sequencer.sv
// Bench for neuron_alu_sequencer: a combinational ALU responder, a
// transaction-level model of the expected op stream and results checked every
// cycle, and directed vectors with literal expected results.
module tb_neuron_alu_sequencer;

   localparam int unsigned NB = 32;
   localparam int unsigned ML = 16;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] in_x = '0;
   logic [NB-1:0] in_w = '0;
   logic          in_last = 1'b0;
   logic [NB-1:0] threshold = '0;
   logic [2:0]    alu_ctrl;
   logic [NB-1:0] alu_src_a;
   logic [NB-1:0] alu_src_b;
   logic [NB-1:0] alu_result;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [NB-1:0] out_sum;
   logic          out_fire;
   logic [CW-1:0] out_count;

   neuron_alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_w(in_w), .in_last(in_last), .threshold(threshold),
      .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_fire(out_fire), .out_count(out_count)
   );

   always #5 clk = ~clk;

   // ALU responder
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_src_a + alu_src_b;
         3'b001:  alu_result = alu_src_a * alu_src_b;
         3'b010:  alu_result = {31'b0, $signed(alu_src_a) < $signed(alu_src_b)};
         default: alu_result = '0;
      endcase
   end

   typedef struct packed {
      logic [2:0]    c;
      logic [NB-1:0] a;
      logic [NB-1:0] b;
   } op_t;

   typedef struct packed {
      logic [NB-1:0] s;
      logic          f;
      logic [CW-1:0] n;
   } res_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   op_t  ops[$];
   res_t exp_q[$];
   res_t got_q[$];
   logic          in_out_m = 1'b0;
   logic [NB-1:0] cur_sum = '0;
   logic [NB-1:0] cur_thr = '0;
   int   cur_n = 0;
   int   start_edge = 0;
   int   last_delta = 0;
   logic prev_ov = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle comparison against the transaction model
   always @(negedge clk) begin
      if (!rst_n) begin
         ops.delete();
         exp_q.delete();
         in_out_m = 1'b0;
         cur_sum  = '0;
         cur_n    = 0;
         prev_ov  = 1'b0;
      end else begin
         logic cmp_now;
         logic [NB-1:0] prd;
         cmp_now = 1'b0;
         chk("out_valid", 64'(out_valid), 64'(in_out_m));
         chk("in_ready", 64'(in_ready), 64'(ops.size() == 0 && !in_out_m));
         if (out_valid && !prev_ov) last_delta = cyc - start_edge;
         prev_ov = out_valid;
         if (in_out_m && exp_q.size() > 0) begin
            chk("out_sum", 64'(out_sum), 64'(exp_q[0].s));
            chk("out_fire", 64'(out_fire), 64'(exp_q[0].f));
            chk("out_count", 64'(out_count), 64'(exp_q[0].n));
         end
         if (ops.size() > 0) begin
            op_t e;
            e = ops.pop_front();
            chk("alu_ctrl", 64'(alu_ctrl), 64'(e.c));
            chk("alu_src_a", 64'(alu_src_a), 64'(e.a));
            chk("alu_src_b", 64'(alu_src_b), 64'(e.b));
            if (e.c == 3'b010) cmp_now = 1'b1;
         end else begin
            chk("alu_idle", {29'b0, alu_ctrl, alu_src_a}, 64'(0));
         end
         if (in_out_m && out_ready) begin
            got_q.push_back('{s: out_sum, f: out_fire, n: out_count});
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            in_out_m = 1'b0;
         end
         if (cmp_now) in_out_m = 1'b1;
         if (in_valid && in_ready) begin
            if (cur_n == 0) begin
               cur_thr    = threshold;
               start_edge = cyc + 1;
            end
            prd = in_x * in_w;
            ops.push_back('{c: 3'b001, a: in_x, b: in_w});
            ops.push_back('{c: 3'b000, a: cur_sum, b: prd});
            cur_sum = cur_sum + prd;
            cur_n++;
            if (in_last || cur_n == ML) begin
               ops.push_back('{c: 3'b010, a: cur_thr, b: cur_sum});
               exp_q.push_back('{s: cur_sum, f: ($signed(cur_thr) < $signed(cur_sum)),
                                 n: CW'(cur_n)});
               cur_sum = '0;
               cur_n   = 0;
            end
         end
      end
   end

   task automatic send_pair(input logic [NB-1:0] x, input logic [NB-1:0] w,
                            input logic last, input logic [NB-1:0] thr);
      int k;
      @(posedge clk);
      #1;
      in_x = x; in_w = w; in_last = last; threshold = thr; in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 200);
      if (!in_ready) chk("handshake_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(output res_t r);
      int k;
      k = 0;
      while (got_q.size() == 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (got_q.size() == 0) begin
         chk("result_timeout", 64'(0), 64'(1));
         r = '0;
      end else begin
         r = got_q.pop_front();
      end
   endtask

   task automatic chk_res(input string name, input res_t r, input logic [NB-1:0] s,
                          input logic f, input int n);
      chk({name, "_sum"}, 64'(r.s), 64'(s));
      chk({name, "_fire"}, 64'(r.f), 64'(f));
      chk({name, "_count"}, 64'(r.n), 64'(n));
   endtask

   initial begin
      res_t r;
      int   k;
      #23;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_alu", {29'b0, alu_ctrl, alu_src_b}, 64'(0));
      chk("rst_out_sum", 64'(out_sum), 64'(0));
      rst_n = 1'b1;
      #10;
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      // Basic fire: 2*3 + 4*(-1) = 2 > 0
      send_pair(32'd2, 32'd3, 1'b0, 32'd0);
      send_pair(32'd4, -32'sd1, 1'b1, 32'd0);
      wait_result(r);
      chk_res("basic", r, 32'd2, 1'b1, 2);
      chk("basic_latency", 64'(last_delta), 64'(6));

      // Equality does not fire
      send_pair(32'd5, 32'd1, 1'b1, 32'd5);
      wait_result(r);
      chk_res("equal", r, 32'd5, 1'b0, 1);

      // Negative sum
      send_pair(-32'sd3, 32'd4, 1'b1, -32'sd20);
      wait_result(r);
      chk_res("neg", r, 32'hFFFF_FFF4, 1'b1, 1);

      // Product wraps to zero; -1 < 0
      send_pair(32'h4000_0000, 32'd4, 1'b1, -32'sd1);
      wait_result(r);
      chk_res("wrap", r, 32'd0, 1'b1, 1);

      // Backpressure: hold OUT for 5 cycles, change threshold meanwhile
      out_ready = 1'b0;
      send_pair(32'd3, 32'd3, 1'b1, 32'd100);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      threshold = 32'd1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_sum", 64'(out_sum), 64'(9));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_result(r);
      chk_res("bp", r, 32'd9, 1'b0, 1);
      send_pair(32'd2, 32'd2, 1'b1, 32'd1);
      wait_result(r);
      chk_res("bp_next", r, 32'd4, 1'b1, 1);

      // Forced termination at MAX_LEN
      for (int i = 0; i < 16; i++) send_pair(32'd1, 32'd1, 1'b0, 32'd0);
      wait_result(r);
      chk_res("forced", r, 32'd16, 1'b1, 16);
      chk("forced_latency", 64'(last_delta), 64'(48));
      send_pair(32'd1, 32'd1, 1'b1, 32'd0);
      wait_result(r);
      chk_res("forced_next", r, 32'd1, 1'b1, 1);

      // Async reset during MUL of the second pair
      send_pair(32'd1, 32'd1, 1'b0, 32'd0);
      send_pair(32'd6, 32'd7, 1'b0, 32'd0);
      chk("pre_rst_ctrl", 64'(alu_ctrl), 64'(1));
      chk("pre_rst_src_a", 64'(alu_src_a), 64'(6));
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu", {29'b0, alu_ctrl, alu_src_a}, 64'(0));
      chk("mid_rst_src_b", 64'(alu_src_b), 64'(0));
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_no_result", 64'(got_q.size()), 64'(0));
      send_pair(32'd1, 32'd7, 1'b1, 32'd0);
      wait_result(r);
      chk_res("after_rst", r, 32'd7, 1'b1, 1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
